// File: rtl/team_06_audio_pkg.sv
// Shared constants and types for the volume ramp controller and its neighbours.
package team_06_audio_pkg;

  localparam int VOL_W   = 4;
  localparam int VOL_MAX = (1 << VOL_W) - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/team_06_tick_divider.sv
// Counts sample ticks while enabled and emits a one-cycle step strobe on the
// STEP_TICKS-th tick. The clear input wins over the strobe, so a tick that
// arrives together with a clear is discarded.
module team_06_tick_divider #(
  parameter int STEP_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  input  logic en,
  output logic step
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

  logic [CW-1:0] count;

  assign step = en & tick & ~clear & (count == LAST);

  // Tick counter, restarting from 0 after each step
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && tick) begin
      if (count == LAST) count <= '0;
      else               count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/team_06_volume_ramp_ctrl.sv
// Walks the volume shifter's level one step at a time toward the effective
// target (target, or 0 when muted / PTT released) to avoid audible clicks.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | vol_out equals the registered effective target
//   RAMP_UP   | vol_out below target, stepping +1 per step strobe
//   RAMP_DOWN | vol_out above target, stepping -1 per step strobe
module team_06_volume_ramp_ctrl #(
  parameter int VOL_W      = team_06_audio_pkg::VOL_W,
  parameter int STEP_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic [VOL_W-1:0] target_vol,
  input  logic             mute,
  input  logic             ptt,
  input  logic             ptt_mode,
  output logic [VOL_W-1:0] vol_out,
  output logic             enable_volume,
  output logic             ramp_busy
);

  import team_06_audio_pkg::*;

  localparam logic [VOL_W-1:0] VOL_TOP = '1;

  ramp_state_t      state, next_state;
  logic [VOL_W-1:0] eff_q;
  logic             div_clear;
  logic             div_en;
  logic             step;

  // Registered effective target; every decision below looks only at eff_q
  always_ff @(posedge clk) begin
    if (rst)                          eff_q <= '0;
    else if (mute || (ptt_mode && !ptt)) eff_q <= '0;
    else                              eff_q <= target_vol;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state follows the comparison of the current level to the target
  always_comb begin
    next_state = IDLE;
    if (vol_out < eff_q)      next_state = RAMP_UP;
    else if (vol_out > eff_q) next_state = RAMP_DOWN;
  end

  // Outputs and divider control; a direction flip restarts the step timer
  always_comb begin
    div_en        = (state != IDLE);
    div_clear     = (next_state == IDLE) || ((state != IDLE) && (next_state != state));
    ramp_busy     = (state != IDLE);
    enable_volume = !((state == IDLE) && (vol_out == '0));
  end

  team_06_tick_divider #(
    .STEP_TICKS (STEP_TICKS)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .tick  (sample_tick),
    .clear (div_clear),
    .en    (div_en),
    .step  (step)
  );

  // Level register; a strobe only fires when the direction still agrees with
  // the target, so the guards below just keep the code free of wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      vol_out <= '0;
    end else if (step) begin
      if (state == RAMP_UP && vol_out != VOL_TOP)   vol_out <= vol_out + VOL_W'(1);
      else if (state == RAMP_DOWN && vol_out != '0) vol_out <= vol_out - VOL_W'(1);
    end
  end

endmodule

// File: tb/tb_team_06_volume_ramp_ctrl.sv
// Directed bench for the volume ramp controller with a per-cycle reference model.
module tb_team_06_volume_ramp_ctrl;

  localparam int VW   = 4;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick;
  logic [VW-1:0] target_vol = '0;
  logic          mute = 1'b0;
  logic          ptt = 1'b0;
  logic          ptt_mode = 1'b0;
  logic [VW-1:0] vol_out;
  logic          enable_volume;
  logic          ramp_busy;

  int checks = 0;
  int errors = 0;

  logic tick_auto = 1'b0;
  logic manual_tick = 1'b0;
  int   tick_phase = 0;
  int   tick_total = 0;

  always #20 clk = ~clk;

  assign sample_tick = manual_tick | (tick_auto && tick_phase == 0);

  always @(negedge clk) tick_phase <= (tick_phase == 9) ? 0 : tick_phase + 1;
  always @(posedge clk) if (sample_tick) tick_total <= tick_total + 1;

  team_06_volume_ramp_ctrl #(
    .VOL_W      (VW),
    .STEP_TICKS (STEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .target_vol    (target_vol),
    .mute          (mute),
    .ptt           (ptt),
    .ptt_mode      (ptt_mode),
    .vol_out       (vol_out),
    .enable_volume (enable_volume),
    .ramp_busy     (ramp_busy)
  );

  // Reference: level, direction (-1/0/+1), ticks accumulated toward the next step
  int m_eff = 0, m_vol = 0, m_dir = 0, m_cnt = 0;
  int want, nvol, ncnt;
  bit started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_eff = 0; m_vol = 0; m_dir = 0; m_cnt = 0;
    end else begin
      want = (m_vol < m_eff) ? 1 : (m_vol > m_eff) ? -1 : 0;
      nvol = m_vol;
      ncnt = m_cnt;
      if (want == 0 || (m_dir != 0 && want != m_dir)) begin
        ncnt = 0;
      end else if (m_dir != 0 && sample_tick) begin
        if (m_cnt + 1 == STEP) begin
          nvol = m_vol + m_dir;
          ncnt = 0;
        end else begin
          ncnt = m_cnt + 1;
        end
      end
      m_dir = want;
      m_vol = nvol;
      m_cnt = ncnt;
      m_eff = (mute || (ptt_mode && !ptt)) ? 0 : int'(target_vol);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model vol_out", int'(vol_out), m_vol);
      chk("model ramp_busy", int'(ramp_busy), (m_dir != 0) ? 1 : 0);
      chk("model enable_volume", int'(enable_volume), (m_dir == 0 && m_vol == 0) ? 0 : 1);
    end
  end

  // Follow vol_out until it reaches fin; every change must be one level toward
  // fin and, when gap_chk is set, exactly STEP ticks after the previous change.
  task automatic watch(input int fin, input bit gap_chk, input string nm);
    int prev;
    int last_t;
    int n;
    prev = int'(vol_out);
    last_t = -1;
    n = 0;
    while (int'(vol_out) != fin && n < 3000) begin
      @(negedge clk);
      n++;
      if (int'(vol_out) != prev) begin
        chk({nm, " step size"}, int'(vol_out) - prev, (fin > prev) ? 1 : -1);
        if (gap_chk && last_t >= 0) chk({nm, " tick gap"}, tick_total - last_t, STEP);
        last_t = tick_total;
        prev = int'(vol_out);
      end
    end
    if (n >= 3000) chk({nm, " timeout"}, int'(vol_out), fin);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int t_mark;

  initial begin
    cycles(3);
    chk("reset vol_out", int'(vol_out), 0);
    chk("reset enable_volume", int'(enable_volume), 0);
    chk("reset ramp_busy", int'(ramp_busy), 0);
    rst = 1'b0;
    tick_auto = 1'b1;
    cycles(2);

    // 0 -> 8: enable two edges after the change, busy drops one cycle after arrival
    target_vol = 4'd8;
    @(negedge clk);
    chk("enable after 1 edge", int'(enable_volume), 0);
    @(negedge clk);
    chk("enable after 2 edges", int'(enable_volume), 1);
    chk("busy after 2 edges", int'(ramp_busy), 1);
    watch(8, 1'b1, "up8");
    chk("busy at arrival", int'(ramp_busy), 1);
    @(negedge clk);
    chk("busy after arrival", int'(ramp_busy), 0);
    chk("hold at 8", int'(vol_out), 8);

    // Settle at 12 then mute
    target_vol = 4'd12;
    watch(12, 1'b1, "up12");
    cycles(3);
    mute = 1'b1;
    watch(0, 1'b1, "mute");
    cycles(2);
    chk("mute enable", int'(enable_volume), 0);
    chk("mute busy", int'(ramp_busy), 0);

    // PTT mode: silent until ptt, down to 0 after release
    mute = 1'b0;
    ptt_mode = 1'b1;
    target_vol = 4'd6;
    cycles(60);
    chk("ptt released stays 0", int'(vol_out), 0);
    chk("ptt released idle", int'(ramp_busy), 0);
    ptt = 1'b1;
    watch(3, 1'b1, "ptt up");
    ptt = 1'b0;
    watch(0, 1'b1, "ptt down");
    cycles(2);
    chk("ptt release enable", int'(enable_volume), 0);
    ptt_mode = 1'b0;

    // Reversal at 5 with a tick landing on the flip cycle
    target_vol = 4'd2;
    watch(2, 1'b1, "to2");
    cycles(3);
    target_vol = 4'd10;
    watch(5, 1'b1, "to5");
    t_mark = tick_total;
    target_vol = 4'd1;
    @(negedge clk);
    manual_tick = 1'b1;
    @(negedge clk);
    manual_tick = 1'b0;
    chk("flip no step", int'(vol_out), 5);
    watch(4, 1'b0, "flip");
    chk("flip gap incl discarded tick", tick_total - t_mark, STEP + 1);
    watch(1, 1'b1, "down1");
    cycles(3);

    // Target equal to current level mid-ramp
    target_vol = 4'd9;
    watch(4, 1'b1, "to4");
    target_vol = 4'd4;
    cycles(2);
    chk("equal target idle", int'(ramp_busy), 0);
    cycles(60);
    chk("equal target no extra step", int'(vol_out), 4);

    // Reset during a ramp
    target_vol = 4'd12;
    watch(7, 1'b1, "to7");
    rst = 1'b1;
    target_vol = 4'd0;
    @(negedge clk);
    chk("rst vol_out", int'(vol_out), 0);
    chk("rst enable", int'(enable_volume), 0);
    chk("rst busy", int'(ramp_busy), 0);
    rst = 1'b0;
    cycles(60);
    chk("no resume after rst", int'(vol_out), 0);
    chk("no resume busy", int'(ramp_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
